// File: rtl/hazard_pkg.sv
// Shared constants, state encoding and width helpers for the hazard/forwarding unit.
package hazard_pkg;

  // Forward-select value meaning "take the operand from the register file".
  localparam int FWD_RF = 0;

  // Stall FSM states.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_e;

  // Width of a forward select: 0 = register file, i+1 = producer slot i.
  function automatic int sel_w(input int num_fwd);
    int w;
    w = $clog2(num_fwd + 1);
    return (w < 1) ? 1 : w;
  endfunction

  // Width of the stall down-counter and of the required-stall value.
  function automatic int cnt_w(input int load_lat, input int num_fwd);
    int m;
    int w;
    m = (load_lat > num_fwd) ? load_lat : num_fwd;
    w = $clog2(m + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/hazard_forward_unit_reg_match.sv
// Single producer/source compare: a producer matches when it writes a non-zero
// register equal to the source address. Register 0 never matches.
module reg_match #(
  parameter int ADDR_W = 5
) (
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [ADDR_W-1:0] src,
  output logic              match
);

  assign match = en & (addr != {ADDR_W{1'b0}}) & (addr == src);

endmodule

// File: rtl/hazard_forward_unit.sv
// EX-stage operand forwarding select and decode-stage RAW hazard stall control,
// with a saturating stall-cycle counter.
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int NUM_FWD  = 2,
  parameter int LOAD_LAT = 1,
  parameter int FWD_EN   = 1,
  localparam int SEL_W   = sel_w(NUM_FWD)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_W-1:0]         ex_rs_addr,
  input  logic [ADDR_W-1:0]         ex_rt_addr,
  input  logic [ADDR_W-1:0]         id_rs_addr,
  input  logic [ADDR_W-1:0]         id_rt_addr,
  input  logic [ADDR_W-1:0]         ex_wr_addr,
  input  logic                      ex_wr_en,
  input  logic                      ex_is_load,
  input  logic [NUM_FWD*ADDR_W-1:0] slot_wr_addr,
  input  logic [NUM_FWD-1:0]        slot_wr_en,
  input  logic                      flush,
  output logic [SEL_W-1:0]          forward_a,
  output logic [SEL_W-1:0]          forward_b,
  output logic                      stall,
  output logic [15:0]               stall_cycles
);

  localparam int CNT_W = cnt_w(LOAD_LAT, NUM_FWD);

  // Producer-slot matches against EX sources (forwarding) and ID sources (hazards).
  logic [NUM_FWD-1:0] ex_rs_hit_s;
  logic [NUM_FWD-1:0] ex_rt_hit_s;
  logic [NUM_FWD-1:0] id_rs_hit_s;
  logic [NUM_FWD-1:0] id_rt_hit_s;
  // EX-stage producer matches against ID sources.
  logic               exp_id_rs_hit_s;
  logic               exp_id_rt_hit_s;

  logic [SEL_W-1:0]   fwd_a_s;
  logic [SEL_W-1:0]   fwd_b_s;
  logic [CNT_W-1:0]   need_s;
  logic               stall_s;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        stall_cycles_q, stall_cycles_d;

  for (genvar g = 0; g < NUM_FWD; g++) begin : g_slot
    reg_match #(.ADDR_W(ADDR_W)) u_ex_rs (
      .en(slot_wr_en[g]), .addr(slot_wr_addr[g*ADDR_W +: ADDR_W]),
      .src(ex_rs_addr), .match(ex_rs_hit_s[g])
    );
    reg_match #(.ADDR_W(ADDR_W)) u_ex_rt (
      .en(slot_wr_en[g]), .addr(slot_wr_addr[g*ADDR_W +: ADDR_W]),
      .src(ex_rt_addr), .match(ex_rt_hit_s[g])
    );
    reg_match #(.ADDR_W(ADDR_W)) u_id_rs (
      .en(slot_wr_en[g]), .addr(slot_wr_addr[g*ADDR_W +: ADDR_W]),
      .src(id_rs_addr), .match(id_rs_hit_s[g])
    );
    reg_match #(.ADDR_W(ADDR_W)) u_id_rt (
      .en(slot_wr_en[g]), .addr(slot_wr_addr[g*ADDR_W +: ADDR_W]),
      .src(id_rt_addr), .match(id_rt_hit_s[g])
    );
  end

  reg_match #(.ADDR_W(ADDR_W)) u_exp_id_rs (
    .en(ex_wr_en), .addr(ex_wr_addr), .src(id_rs_addr), .match(exp_id_rs_hit_s)
  );
  reg_match #(.ADDR_W(ADDR_W)) u_exp_id_rt (
    .en(ex_wr_en), .addr(ex_wr_addr), .src(id_rt_addr), .match(exp_id_rt_hit_s)
  );

  // Priority select: scan oldest to youngest so the youngest matching slot wins.
  always_comb begin
    fwd_a_s = SEL_W'(FWD_RF);
    fwd_b_s = SEL_W'(FWD_RF);
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      fwd_a_s = ex_rs_hit_s[i] ? SEL_W'(i + 1) : fwd_a_s;
      fwd_b_s = ex_rt_hit_s[i] ? SEL_W'(i + 1) : fwd_b_s;
    end
  end

  // Forward outputs: forced to the register file in stall-only mode or reset.
  always_comb begin
    if ((FWD_EN != 0) && !rst) begin
      forward_a = fwd_a_s;
      forward_b = fwd_b_s;
    end else begin
      forward_a = SEL_W'(FWD_RF);
      forward_b = SEL_W'(FWD_RF);
    end
  end

  // Required stall length: maximum over every producer the decode sources depend on.
  always_comb begin
    need_s = CNT_W'(0);
    if (FWD_EN != 0) begin
      if ((exp_id_rs_hit_s | exp_id_rt_hit_s) & ex_is_load) begin
        need_s = CNT_W'(LOAD_LAT);
      end else begin
        need_s = CNT_W'(0);
      end
    end else begin
      if (exp_id_rs_hit_s | exp_id_rt_hit_s) begin
        need_s = CNT_W'(NUM_FWD);
      end else begin
        need_s = CNT_W'(0);
      end
      // Slot i still needs NUM_FWD-1-i cycles before the write-first RF sees it.
      for (int i = 0; i < NUM_FWD; i++) begin
        if ((id_rs_hit_s[i] | id_rt_hit_s[i]) && (CNT_W'(NUM_FWD - 1 - i) > need_s)) begin
          need_s = CNT_W'(NUM_FWD - 1 - i);
        end else begin
          need_s = need_s;
        end
      end
    end
  end

  // Stall FSM next state: flush wins, IDLE stalls combinationally, STALL counts down.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_s = 1'b0;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = CNT_W'(0);
      stall_s = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          stall_s = (need_s != CNT_W'(0));
          if (need_s > CNT_W'(1)) begin
            cnt_d   = need_s - CNT_W'(1);
            state_d = STALL;
          end else begin
            cnt_d   = cnt_q;
            state_d = IDLE;
          end
        end
        STALL: begin
          stall_s = 1'b1;
          cnt_d   = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = IDLE;
          end else begin
            state_d = STALL;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = CNT_W'(0);
          stall_s = 1'b0;
        end
      endcase
    end
  end

  // Stall output is gated by reset so a reset mid-stall aborts it immediately.
  always_comb begin
    if (rst) begin
      stall = 1'b0;
    end else begin
      stall = stall_s;
    end
  end

  // Saturating count of cycles in which stall is asserted.
  always_comb begin
    if (stall && (stall_cycles_q != 16'hFFFF)) begin
      stall_cycles_d = stall_cycles_q + 16'd1;
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
  end

  // State, down-counter and performance counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= CNT_W'(0);
      stall_cycles_q <= 16'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule
